ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
Instruction fetch controller between the control unit and the instruction RAM. It owns the 8-bit program counter, drives the IRAM address and absorbs the IRAM's 1-cycle registered read latency. It delivers opcodes and branch operand bytes to the control unit over a req/valid handshake. It resolves JUMP/JMPZ/JMNZ targets by loading the PC from the operand byte.

Parameters:
- PROG_DEPTH, 121: number of valid IRAM words; legal PC range is 0..PROG_DEPTH-1.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- pc  out  8  IRAM address; connects to IRAM addr.
- iram_dout  in  8  IRAM read data, valid one clock after pc is presented.
- fetch_req  in  1  request next opcode; sampled only in IDLE.
- br_req  in  1  request branch resolution using the operand byte at pc; sampled only in IDLE.
- br_take  in  1  branch condition (1 = take), sampled with br_req.
- busy  out  1  high in every state except IDLE and HALT.
- ir  out  8  last fetched opcode.
- ir_valid  out  1  one-cycle pulse when ir is updated.
- br_done  out  1  one-cycle pulse when branch resolution completes.
- br_target  out  8  operand byte captured by the last branch.
- halted  out  1  high in HALT.
- pc_fault  out  1  sticky; set when the PC would leave the legal range.
- fetch_count  out  16  fetched-opcode counter; see Optional Feature.

Behaviour:
- Reset values: pc=RESET_PC, ir=0, ir_valid=0, br_done=0, br_target=0, busy=0, halted=0, pc_fault=0, fetch_count=0, state=IDLE.
- Reset mid-operation returns to IDLE at the same edge. Any in-flight IRAM read is discarded and produces no valid pulse.
- States: IDLE, F_WAIT, F_CAP, B_WAIT, B_CAP, HALT.
- IDLE:
  - fetch_req=1 -> F_WAIT.
  - br_req=1 -> B_WAIT, and br_take is latched internally.
  - fetch_req and br_req both 1 -> br_req wins; the fetch is dropped and the control unit must reissue it.
  - Otherwise stay in IDLE.
- F_WAIT: pc is held; the IRAM registers ROM[pc]. Next state F_CAP.
- F_CAP:
  - ir <= iram_dout; ir_valid pulses in the following cycle.
  - pc <= pc+1. Next state IDLE.
  - Opcode-to-valid latency is 2 clocks after the accepting edge.
  - If iram_dout == NOP and pc == PROG_DEPTH-1 -> HALT instead of IDLE; pc is not incremented.
- B_WAIT: pc (the operand address) is held. Next state B_CAP.
- B_CAP:
  - br_target <= iram_dout; br_done pulses in the following cycle.
  - Latched take=1 -> pc <= iram_dout.
  - Latched take=0 -> pc <= pc+1.
  - Next state IDLE.
- Range check: any PC update with a result >= PROG_DEPTH sets pc_fault, holds pc and enters HALT. This covers pc+1 and a branch target. 8-bit wrap (255->0) is never taken.
- HALT: absorbing state; all requests are ignored, busy=0 and halted=1. Only rst leaves HALT.
- busy=1 in F_WAIT, F_CAP, B_WAIT and B_CAP. Requests seen while busy are ignored, not queued.
- ir_valid and br_done are never high in the same cycle.

Optional Feature:
- Macro: IFETCH_PERFCNT_EN.
- Defined: fetch_count increments by 1 on every ir_valid pulse. It saturates at 16'hFFFF and clears on rst.
- Undefined: no counter logic is built; fetch_count is tied to 0.

Decomposition:
- Shared package ifetch_pkg holds:
  - the state encoding (3-bit localparams IDLE..HALT);
  - opcode constants NOP=2, JUMP=29, JMPZ=32, JMNZ=37 (used by the bench and by the halt detect);
  - the IRAM address width, 8.
- One sub-module, ifetch_pc, holds the PC register with hold/increment/load, the PROG_DEPTH bound check and the fault output. The FSM stays in ifetch_ctrl.

Test Plan:
- Reset then fetch: IRAM holds ROM[0]=7. Pulse fetch_req -> ir=7, ir_valid pulses exactly 2 clocks after acceptance, pc=1.
- Sequential fetch: 4 back-to-back requests, each issued when busy=0 -> ir sequence is ROM[0..3], pc=4.
- Taken branch: pc=104, ROM[104]=120, br_req=1 with br_take=1 -> br_target=120, br_done pulses, pc=120.
- Untaken branch: pc=108, ROM[108]=21, br_take=0 -> br_target=21, pc=109.
- Halt and fault:
  - Fetch at pc=120 where ROM[120]=NOP -> halted=1; a later fetch_req is ignored.
  - Separately, a branch with target 200 -> pc_fault=1, halted=1, pc unchanged.
- Collision and reset: fetch_req and br_req asserted together -> branch path taken and no ir_valid. Then rst asserted during F_WAIT -> next cycle pc=0, no ir_valid, and fetch_count=0 with IFETCH_PERFCNT_EN defined.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, opcode constants and the IRAM address width.
package ifetch_pkg;

   localparam int ADDR_W = 8;

   // 3-bit state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_F_WAIT = 3'd1;
   localparam logic [2:0] ST_F_CAP  = 3'd2;
   localparam logic [2:0] ST_B_WAIT = 3'd3;
   localparam logic [2:0] ST_B_CAP  = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      F_WAIT = ST_F_WAIT,
      F_CAP  = ST_F_CAP,
      B_WAIT = ST_B_WAIT,
      B_CAP  = ST_B_CAP,
      HALT   = ST_HALT
   } state_t;

   // Opcodes the fetch path cares about
   localparam logic [7:0] NOP  = 8'd2;
   localparam logic [7:0] JUMP = 8'd29;
   localparam logic [7:0] JMPZ = 8'd32;
   localparam logic [7:0] JMNZ = 8'd37;

endpackage

// File: rtl/ifetch_pc.sv
// Program counter with hold / increment / load and a bound check against
// PROG_DEPTH. An update whose result is out of range is refused, the PC is
// held and the sticky fault flag is raised instead.
module ifetch_pc
   import ifetch_pkg::*;
#(
   parameter int PROG_DEPTH = 121,
   parameter int RESET_PC   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc,
   output logic              inc_err,
   output logic              load_err,
   output logic              pc_fault
);

   // One extra bit so pc+1 never silently wraps 255 -> 0.
   logic [ADDR_W:0] pc_plus1;
   logic [ADDR_W:0] load_ext;

   // Out-of-range detection for both candidate results, independent of which is chosen
   always_comb begin
      pc_plus1 = {1'b0, pc} + 9'd1;
      load_ext = {1'b0, load_val};
      inc_err  = (pc_plus1 >= 9'(PROG_DEPTH));
      load_err = (load_ext >= 9'(PROG_DEPTH));
   end

   // PC register and sticky fault flag
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= ADDR_W'(RESET_PC);
         pc_fault <= 1'b0;
      end else if (load) begin
         if (load_err) pc_fault <= 1'b1;
         else          pc       <= load_val;
      end else if (inc) begin
         if (inc_err)  pc_fault <= 1'b1;
         else          pc       <= pc_plus1[ADDR_W-1:0];
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequences IRAM reads for opcode fetches and
// branch operand reads, absorbing the IRAM's one-cycle read latency.
// Optional feature: define IFETCH_PERFCNT_EN to build the fetched-opcode
// counter; otherwise fetch_count is tied to zero.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int PROG_DEPTH = 121,
   parameter int RESET_PC   = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] pc,
   input  logic [7:0]        iram_dout,
   input  logic              fetch_req,
   input  logic              br_req,
   input  logic              br_take,
   output logic              busy,
   output logic [7:0]        ir,
   output logic              ir_valid,
   output logic              br_done,
   output logic [7:0]        br_target,
   output logic              halted,
   output logic              pc_fault,
   output logic [15:0]       fetch_count
);

   state_t state, state_nxt;
   logic   take_q;
   logic   pc_inc, pc_load;
   logic   inc_err, load_err;
   logic   ir_cap, br_cap;

   ifetch_pc #(
      .PROG_DEPTH (PROG_DEPTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (iram_dout),
      .pc       (pc),
      .inc_err  (inc_err),
      .load_err (load_err),
      .pc_fault (pc_fault)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and PC/capture control
   // NOTE: every signal gets a default first so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_nxt = state;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ir_cap    = 1'b0;
      br_cap    = 1'b0;
      case (state)
         IDLE: begin
            // A simultaneous fetch is dropped; the control unit reissues it.
            if (br_req)         state_nxt = B_WAIT;
            else if (fetch_req) state_nxt = F_WAIT;
         end
         F_WAIT: state_nxt = F_CAP;
         F_CAP: begin
            ir_cap = 1'b1;
            if (iram_dout == NOP && pc == ADDR_W'(PROG_DEPTH - 1)) begin
               state_nxt = HALT;
            end else begin
               pc_inc    = 1'b1;
               state_nxt = inc_err ? HALT : IDLE;
            end
         end
         B_WAIT: state_nxt = B_CAP;
         B_CAP: begin
            br_cap = 1'b1;
            if (take_q) begin
               pc_load   = 1'b1;
               state_nxt = load_err ? HALT : IDLE;
            end else begin
               pc_inc    = 1'b1;
               state_nxt = inc_err ? HALT : IDLE;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // Opcode / branch-target capture, completion pulses and branch condition latch
   always_ff @(posedge clk) begin
      if (rst) begin
         ir        <= '0;
         ir_valid  <= 1'b0;
         br_done   <= 1'b0;
         br_target <= '0;
         take_q    <= 1'b0;
      end else begin
         ir_valid <= ir_cap;
         br_done  <= br_cap;
         if (ir_cap) ir        <= iram_dout;
         if (br_cap) br_target <= iram_dout;
         if (state == IDLE && br_req) take_q <= br_take;
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      busy   = (state == F_WAIT) || (state == F_CAP) ||
               (state == B_WAIT) || (state == B_CAP);
      halted = (state == HALT);
   end

`ifdef IFETCH_PERFCNT_EN
   // Saturating count of captured opcodes, advancing together with ir
   always_ff @(posedge clk) begin
      if (rst)                                fetch_count <= '0;
      else if (ir_cap && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
   end
`else
   assign fetch_count = '0;
`endif

endmodule
